bank_spi_loader: RTL
====================

Name: bank_spi_loader

Overview:
- SPI slave that receives framed serial data and writes it byte-by-byte into the on-chip weight/input memory banks through their write port (csen/wrenb/addr_b/data_b).
- Replaces the simulation-only file preload with a synthesizable load path driven by the external MCU.
- Sits between the chip SPI pads and the NUM_BANKS memory banks; one instance is shared by all banks.

Parameters:
ADDR_WIDTH, 13, bank address width; matches the bank write-port address.
DATA_WIDTH, 8, bank data width; fixed at one SPI byte.
DATA_DEPTH, 1024, words per bank; the upper limit for legal writes.
NUM_BANKS, 8, number of banks selectable by bank id.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
spi_sclk  in  1  SPI clock, mode 0, asynchronous to clk, frequency <= clk/4
spi_cs_n  in  1  SPI chip select, active low, asynchronous
spi_mosi  in  1  SPI data, MSB first
csen  out  NUM_BANKS  one-hot bank select, asserted only during a write
wrenb  out  1  write strobe to banks
addr_b  out  ADDR_WIDTH  bank write address
data_b  out  DATA_WIDTH  bank write data
busy  out  1  high from the first received bit until the frame ends
done  out  1  one-cycle pulse when a frame completes cleanly
err  out  1  sticky error flag; cleared at the next frame start

Behaviour:
- Reset is asynchronous and active-high. All outputs reset to 0, the FSM goes to IDLE and all counters clear.
- spi_sclk, spi_cs_n and spi_mosi each pass through a 2-flop synchronizer. A rising sclk edge is detected on the synchronized signals, and mosi is sampled on that edge. Shift-in is MSB first; every 8 bits forms one byte.
- Frame format: bank id (1 byte), start address (2 bytes, big-endian, upper bits ignored beyond ADDR_WIDTH), length N (2 bytes, big-endian, number of data bytes), then N data bytes.
- FSM states: IDLE, HDR, DATA, DONE.
  - IDLE -> HDR on the synchronized cs_n falling edge. Clears err and the byte count, sets busy.
  - HDR collects 5 bytes. If N == 0, go straight to DONE. Otherwise go to DATA.
  - DATA: one cycle after each completed byte, drive wrenb = 1, csen = one-hot(bank), addr_b = current address, data_b = byte, for exactly one cycle. The address then increments. After N bytes, go to DONE.
  - DONE: done pulses for one cycle if err == 0, busy drops, return to IDLE.
- Write latency is 1 clk after the byte-complete sclk edge is detected. Outside write cycles, csen, wrenb, addr_b and data_b are held at 0.
- Bank id >= NUM_BANKS: set err. The data bytes are still consumed and counted, but no write is issued.
- Address >= DATA_DEPTH (at start or after increment): set err and suppress that write. The address does not wrap.
- cs_n rising before the frame completes: abort to IDLE and set err. No done pulse. Writes already issued remain.
- Extra bytes after N data bytes while cs_n is still low are ignored until cs_n rises. The next frame requires a new cs_n falling edge.
- A simultaneous byte completion and cs_n rise counts the byte as received, then aborts.
- Reset mid-frame: immediate return to IDLE with outputs at 0. A partial frame is not resumed.

Optional Feature:
- Macro: BANK_LOADER_CHECKSUM_EN
- With the macro: the frame carries one extra trailing byte after the data, in a CHK state. It equals the XOR of the bank id, the 4 header bytes and all data bytes. A mismatch sets err and suppresses done. The data writes have already occurred and are not rolled back.
- Without the macro: there is no CHK state and no trailing byte. done follows the last data write.

Decomposition:
- Shared package ecg_mem_pkg holds:
  - state encoding (IDLE, HDR, DATA, CHK, DONE)
  - HDR_BYTES = 5
  - bank-id width = clog2(NUM_BANKS)
  - the default ADDR_WIDTH, DATA_WIDTH and DATA_DEPTH
- One sub-module, spi_byte_rx, contains the synchronizers, sclk edge detection and shift register. It outputs byte_valid (1-cycle pulse), byte_data, cs_fall and cs_rise.
- The framing FSM and write generation stay in bank_spi_loader.

Test Plan:
- Frame bank=2, addr=0x0010, N=3, data A5 3C FF: expect 3 single-cycle writes with csen = 8'b0000_0100 to addr 0x10, 0x11, 0x12, then done = 1 for one cycle and err = 0.
- bank=9 (>= NUM_BANKS), N=2: expect no wrenb, err = 1, no done, busy drops after cs_n rise.
- addr=0x03FE, N=4: expect writes to 0x3FE and 0x3FF only, then err = 1, no writes at 0x400 or above, no done.
- N=0 frame: expect done after the 5th header byte with zero writes. An abort after byte 2 of a second frame sets err = 1 with no writes.
- Assert rst during the DATA state after 1 of 4 bytes: all outputs go to 0 immediately. The next full frame loads correctly and err is cleared at its start.
- With BANK_LOADER_CHECKSUM_EN: a correct XOR byte gives done = 1. A corrupted XOR (bit 0 flipped) gives err = 1 and no done, and the data writes are still present in the bank.

Source files
------------

// File: rtl/ecg_mem_pkg.sv
// Shared definitions for the memory-bank load path: FSM encoding, header size,
// default bank geometry and the bank-id width helper.
package ecg_mem_pkg;

    localparam int ADDR_WIDTH_DEF = 13;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int DATA_DEPTH_DEF = 1024;
    localparam int NUM_BANKS_DEF  = 8;
    localparam int HDR_BYTES      = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CHK,
        ST_DONE
    } ld_state_t;

    function automatic int bank_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BANK_ID_W = bank_id_w(NUM_BANKS_DEF);

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver: 2-flop synchronizers on sclk/cs_n/mosi, sclk rising
// edge detect and MSB-first shift register. byte_valid is a 1-cycle pulse.
module spi_byte_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       cs_fall,
    output logic       cs_rise
);

    logic [1:0] sclk_sy, cs_sy, mosi_sy;
    logic       sclk_d, cs_d;
    logic [6:0] shreg;
    logic [2:0] bit_cnt;
    logic       sclk_rise;

    // cs_n resets high so reset release never looks like a frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sy <= 2'b00;
            cs_sy   <= 2'b11;
            mosi_sy <= 2'b00;
            sclk_d  <= 1'b0;
            cs_d    <= 1'b1;
        end else begin
            sclk_sy <= {sclk_sy[0], spi_sclk};
            cs_sy   <= {cs_sy[0], spi_cs_n};
            mosi_sy <= {mosi_sy[0], spi_mosi};
            sclk_d  <= sclk_sy[1];
            cs_d    <= cs_sy[1];
        end
    end

    assign sclk_rise = sclk_sy[1] & ~sclk_d;
    assign cs_fall   = ~cs_sy[1] & cs_d;
    assign cs_rise   = cs_sy[1] & ~cs_d;

    // Gating on the delayed cs lets a byte finishing in the cs-rise cycle still count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (cs_d) begin
            bit_cnt <= '0;
        end else if (sclk_rise) begin
            shreg   <= {shreg[5:0], mosi_sy[1]};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    assign byte_valid = sclk_rise & ~cs_d & (bit_cnt == 3'd7);
    assign byte_data  = {shreg, mosi_sy[1]};

endmodule

// File: rtl/bank_spi_loader.sv
// SPI frame loader writing bytes into the memory banks' write port.
// Optional BANK_LOADER_CHECKSUM_EN adds a trailing XOR byte checked in ST_CHK.
module bank_spi_loader
    import ecg_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DATA_DEPTH = DATA_DEPTH_DEF,
    parameter int NUM_BANKS  = NUM_BANKS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic [NUM_BANKS-1:0]  csen,
    output logic                  wrenb,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] data_b,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BW = bank_id_w(NUM_BANKS);
    localparam logic [7:0]          NB_L    = 8'(NUM_BANKS);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DATA_DEPTH);
`ifdef BANK_LOADER_CHECKSUM_EN
    localparam ld_state_t TAIL = ST_CHK;
`else
    localparam ld_state_t TAIL = ST_DONE;
`endif

    logic       byte_valid, cs_fall, cs_rise;
    logic [7:0] byte_data;

    spi_byte_rx u_rx (
        .clk        (clk),
        .rst        (rst),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .cs_fall    (cs_fall),
        .cs_rise    (cs_rise)
    );

    ld_state_t           state, state_nx;
    logic [2:0]          hdr_cnt;
    logic [7:0]          bank_id;
    logic [7:0]          addr_hi;
    logic [ADDR_WIDTH:0] addr;       // one spare bit so the limit compare never wraps
    logic [15:0]         len, data_cnt;
    logic                bank_ok, addr_ok, aborting;
`ifdef BANK_LOADER_CHECKSUM_EN
    logic [7:0]          chk;
`endif

    assign bank_ok  = (bank_id < NB_L);
    assign addr_ok  = (addr < DEPTH_L);
    assign aborting = (state_nx == ST_IDLE) &&
                      (state == ST_HDR || state == ST_DATA || state == ST_CHK);

    // A byte completing alongside cs rise is consumed before the abort is taken
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (cs_fall) state_nx = ST_HDR;
            ST_HDR: begin
                if (byte_valid && hdr_cnt == 3'(HDR_BYTES - 1))
                    state_nx = ({len[15:8], byte_data} == 16'd0) ? TAIL : ST_DATA;
                else if (cs_rise)
                    state_nx = ST_IDLE;
            end
            ST_DATA: begin
                if (byte_valid && data_cnt == len - 16'd1) state_nx = TAIL;
                else if (cs_rise)                          state_nx = ST_IDLE;
            end
`ifdef BANK_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (byte_valid)   state_nx = ST_DONE;
                else if (cs_rise) state_nx = ST_IDLE;
            end
`endif
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            hdr_cnt  <= '0;
            bank_id  <= '0;
            addr_hi  <= '0;
            addr     <= '0;
            len      <= '0;
            data_cnt <= '0;
            csen     <= '0;
            wrenb    <= 1'b0;
            addr_b   <= '0;
            data_b   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef BANK_LOADER_CHECKSUM_EN
            chk      <= '0;
`endif
        end else begin
            state  <= state_nx;
            csen   <= '0;
            wrenb  <= 1'b0;
            addr_b <= '0;
            data_b <= '0;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        hdr_cnt  <= '0;
                        data_cnt <= '0;
`ifdef BANK_LOADER_CHECKSUM_EN
                        chk      <= '0;
`endif
                    end
                end
                ST_HDR: begin
                    if (byte_valid) begin
                        hdr_cnt <= hdr_cnt + 3'd1;
                        case (hdr_cnt)
                            3'd0: begin
                                bank_id <= byte_data;
                                if (byte_data >= NB_L) err <= 1'b1;
                            end
                            3'd1: addr_hi <= byte_data;
                            3'd2: addr <= {1'b0, ADDR_WIDTH'({addr_hi, byte_data})};
                            3'd3: len[15:8] <= byte_data;
                            3'd4: len[7:0]  <= byte_data;
                            default: ;
                        endcase
                    end
                end
                ST_DATA: begin
                    if (byte_valid) begin
                        data_cnt <= data_cnt + 16'd1;
                        if (!addr_ok) begin
                            err <= 1'b1;
                        end else begin
                            addr <= addr + (ADDR_WIDTH + 1)'(1);
                            if (bank_ok) begin
                                wrenb  <= 1'b1;
                                csen   <= NUM_BANKS'(1) << bank_id[BW-1:0];
                                addr_b <= addr[ADDR_WIDTH-1:0];
                                data_b <= DATA_WIDTH'(byte_data);
                            end
                        end
                    end
                end
`ifdef BANK_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (byte_valid && byte_data != chk) err <= 1'b1;
                end
`endif
                ST_DONE: begin
                    done <= ~err;
                    busy <= 1'b0;
                end
                default: ;
            endcase
            if (aborting) begin
                err  <= 1'b1;
                busy <= 1'b0;
            end
`ifdef BANK_LOADER_CHECKSUM_EN
            if (byte_valid && (state == ST_HDR || state == ST_DATA))
                chk <= chk ^ byte_data;
`endif
        end
    end

endmodule
